// File: rtl/mac_block_accumulator_pkg.sv
// Shared parameters and state encodings for the multiply-add block accumulator.
package mac_block_accumulator_pkg;
  localparam int P      = 8;
  localparam int LOG2N  = 3;
  localparam int N      = 1 << LOG2N;
  localparam int DATA_W = 2 * P;
  localparam int ACC_W  = DATA_W + LOG2N;

  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  typedef enum logic {IN_IDLE, IN_ACC} in_state_e;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;
endpackage

// File: rtl/mac_block_accumulator.sv
// Sums blocks of N multiply-add results and offers each block sum/mean on a
// valid/ready port; a block finishing while the previous one is unread is dropped.
//
// state     | meaning
// IN_IDLE   | no samples in the current block (cnt = 0, acc = 0)
// IN_ACC    | block in progress, 0 < cnt < N
// OUT_EMPTY | no unconsumed result, out_valid = 0
// OUT_FULL  | sum/mean hold an unconsumed result, out_valid = 1
module mac_block_accumulator
  import mac_block_accumulator_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  sum,
  output logic [DATA_W-1:0] mean,
  output logic [LOG2N-1:0]  cnt,
  output logic              ovf
);

  in_state_e         in_state_q, in_state_d;
  out_state_e        out_state_q, out_state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2N-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] mean_q, mean_d;
  logic              ovf_q, ovf_d;

  logic              complete;
  logic              xfer;
  logic [ACC_W-1:0]  result;

  assign complete = in_valid && (cnt_q == CNT_LAST);
  assign xfer     = (out_state_q == OUT_FULL) && out_ready;
  assign result   = acc_q + ACC_W'(data_in);

  always_comb begin
    in_state_d = in_state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    if (clr) begin
      in_state_d = IN_IDLE;
      acc_d      = '0;
      cnt_d      = '0;
    end else if (in_valid) begin
      if (complete) begin
        in_state_d = IN_IDLE;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        in_state_d = IN_ACC;
        acc_d      = result;
        cnt_d      = cnt_q + LOG2N'(1);
      end
    end
  end

  // A transfer in the completion cycle frees the register, so the new result loads.
  always_comb begin
    out_state_d = out_state_q;
    sum_d       = sum_q;
    mean_d      = mean_q;
    ovf_d       = ovf_q;
    if (clr) begin
      out_state_d = OUT_EMPTY;
      sum_d       = '0;
      mean_d      = '0;
      ovf_d       = 1'b0;
    end else if (complete && (out_state_q == OUT_EMPTY || xfer)) begin
      out_state_d = OUT_FULL;
      sum_d       = result;
      mean_d      = result[ACC_W-1:LOG2N];
    end else if (complete) begin
      ovf_d = 1'b1;
    end else if (xfer) begin
      out_state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q <= IN_IDLE;
    end else begin
      in_state_q <= in_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q <= OUT_EMPTY;
      sum_q       <= '0;
      mean_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      sum_q       <= sum_d;
      mean_q      <= mean_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = (out_state_q == OUT_FULL);
  assign sum       = sum_q;
  assign mean      = mean_q;
  assign cnt       = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_block_accumulator.sv
// Directed and randomized checks of mac_block_accumulator against a
// sample-count/running-sum reference model.
module tb_mac_block_accumulator;
  import mac_block_accumulator_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              clr;
  logic              out_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] mean;
  logic [LOG2N-1:0]  cnt;
  logic              ovf;

  int checks   = 0;
  int failures = 0;

  // reference model: samples so far, running total, held result
  int m_cnt, m_run, m_sum, m_valid, m_ovf;

  mac_block_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .clr(clr), .out_ready(out_ready), .out_valid(out_valid), .sum(sum),
    .mean(mean), .cnt(cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_run = 0; m_sum = 0; m_valid = 0; m_ovf = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".sum"},       32'(sum),       32'(m_sum));
    check({tag, ".mean"},      32'(mean),      32'(m_sum / N));
    check({tag, ".cnt"},       32'(cnt),       32'(m_cnt));
    check({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic v, input int d, input logic rdy, input logic c, input string tag);
    int  res;
    bit  done;
    bit  taken;
    in_valid  = v;
    data_in   = DATA_W'(d);
    out_ready = rdy;
    clr       = c;
    @(posedge clk);
    taken = (m_valid != 0) && rdy;
    done  = 0;
    res   = 0;
    if (c) begin
      model_reset();
    end else begin
      if (v) begin
        m_run += d;
        m_cnt++;
        if (m_cnt == N) begin
          done = 1; res = m_run; m_run = 0; m_cnt = 0;
        end
      end
      if (done && (m_valid == 0 || taken)) begin
        m_sum = res; m_valid = 1;
      end else if (done) begin
        m_ovf = 1;
      end else if (taken) begin
        m_valid = 0;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      data_in   = DATA_W'($urandom);
      clr       = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      check_all("reset");
    end
    rst_n = 1'b1;
    step(0, 0, 1, 0, "post_reset");
    step(0, 0, 1, 0, "post_reset");

    // basic block 1..8
    for (int i = 1; i <= N; i++) step(1, i, 1, 0, "basic");
    check("basic.valid_lit", 32'(out_valid), 1);
    check("basic.sum_lit", 32'(sum), 36);
    check("basic.mean_lit", 32'(mean), 4);
    step(0, 0, 1, 0, "basic_after");
    check("basic.pulse_lit", 32'(out_valid), 0);

    // maximal inputs
    for (int i = 0; i < N; i++) step(1, 16'hFFFF, 1, 0, "max");
    check("max.sum_lit", 32'(sum), 524280);
    check("max.mean_lit", 32'(mean), 16'hFFFF);

    // gapped input
    for (int i = 0; i < 16; i++) step(((i % 2) == 0), 10, 1, 0, "gapped");
    check("gapped.sum_lit", 32'(sum), 80);
    check("gapped.mean_lit", 32'(mean), 10);

    // backpressure and drop
    for (int i = 0; i < N; i++) step(1, 1, 0, 0, "bp_ones");
    check("bp.sum_lit", 32'(sum), 8);
    check("bp.valid_lit", 32'(out_valid), 1);
    for (int i = 0; i < N; i++) step(1, 2, 0, 0, "bp_twos");
    check("bp.ovf_lit", 32'(ovf), 1);
    check("bp.sum_kept_lit", 32'(sum), 8);
    step(0, 0, 1, 0, "bp_take");
    check("bp.taken_lit", 32'(out_valid), 0);
    step(0, 0, 0, 1, "bp_clr");
    check("bp.ovf_clr_lit", 32'(ovf), 0);
    check("bp.sum_clr_lit", 32'(sum), 0);

    // reset mid-block
    for (int i = 0; i < 5; i++) step(1, 7, 1, 0, "mid");
    check("mid.cnt_before_lit", 32'(cnt), 5);
    rst_n = 1'b0;
    #1;
    check("mid.cnt_async_lit", 32'(cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) step(1, 3, 1, 0, "mid_after");
    check("mid.sum_lit", 32'(sum), 24);
    check("mid.mean_lit", 32'(mean), 3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, rdy, c;
      int   d;
      v   = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : int'($urandom_range(0, 16'hFFFF));
      rdy = ($urandom_range(0, 2) == 0);
      c   = ($urandom_range(0, 149) == 0);
      step(v, d, rdy, c, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
